stage5_lane_dispatch: RTL and testbench

- Sequences the stage-5 field-extraction lanes. Accepts one parsed message per cycle from stage 4 over a valid/ready stream.
- Assigns each message round-robin to a free lane among three. Each lane holds its message until the downstream sink releases it.
- Drives the per-lane message buses, per-lane mux-control codes and the shared message_en consumed by the stage-5 field extractors (OIV4 and siblings).

---
 rtl/stage5_lane_dispatch_pkg.sv | 31 +++
 rtl/stage5_rr_pick3.sv | 30 +++
 rtl/stage5_lane_dispatch.sv | 134 +++++++++++++
 tb/tb_stage5_lane_dispatch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage5_lane_dispatch_pkg.sv
// Shared definitions for the stage-5 three-lane dispatcher: lane count, idle code,
// recognised mux-control codes, lane state encoding and pointer helpers.
package stage5_lane_dispatch_pkg;

  localparam int LANES         = 3;
  localparam int DEF_MSG_W     = 64;
  localparam int DEF_CTRL_W    = 4;
  localparam int DEF_IDLE_CODE = 0;

  // Mux-control codes understood by the stage-5 extractors; IDLE_CODE is deliberately not listed.
  localparam int MUX_CODE_A = 1;
  localparam int MUX_CODE_B = 2;
  localparam int MUX_CODE_C = 3;
  localparam int MUX_CODE_D = 4;

  typedef enum logic {
    LANE_FREE = 1'b0,
    LANE_BUSY = 1'b1
  } lane_state_e;

  function automatic logic is_valid_code(input logic [31:0] code);
    return (code == 32'(MUX_CODE_A)) || (code == 32'(MUX_CODE_B)) ||
           (code == 32'(MUX_CODE_C)) || (code == 32'(MUX_CODE_D));
  endfunction

  // Lane index successor modulo three; an out-of-range index wraps to lane 0.
  function automatic logic [1:0] next_lane(input logic [1:0] lane);
    return (lane >= 2'd2) ? 2'd0 : lane + 2'd1;
  endfunction

endpackage

// File: rtl/stage5_rr_pick3.sv
// Combinational three-way round-robin picker: one-hot grant of the first set mask bit
// at or after the pointer, plus the pointer value that follows that grant.
module stage5_rr_pick3
  import stage5_lane_dispatch_pkg::*;
(
  input  logic [LANES-1:0] i_mask,
  input  logic [1:0]       i_ptr,
  output logic [LANES-1:0] o_grant,
  output logic             o_any,
  output logic [1:0]       o_next_ptr
);

  logic [1:0] w_cand;

  always_comb begin
    o_grant    = '0;
    o_any      = 1'b0;
    w_cand     = (i_ptr > 2'd2) ? 2'd0 : i_ptr;
    o_next_ptr = w_cand;
    for (int k = 0; k < LANES; k++) begin
      if (!o_any && i_mask[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_any           = 1'b1;
        o_next_ptr      = next_lane(w_cand);
      end
      w_cand = next_lane(w_cand);
    end
  end

endmodule

// File: rtl/stage5_lane_dispatch.sv
// Stage-5 lane dispatcher: accepts stage-4 messages and parks each in one of three lanes
// until the sink releases it. Optional unknown-type dropping under DISPATCH_TYPE_FILTER_EN.
module stage5_lane_dispatch
  import stage5_lane_dispatch_pkg::*;
#(
  parameter int                MSG_W     = DEF_MSG_W,
  parameter int                CTRL_W    = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0] IDLE_CODE = CTRL_W'(DEF_IDLE_CODE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MSG_W-1:0]  in_message,
  input  logic [CTRL_W-1:0] in_type,
  input  logic [2:0]        lane_done,
  output logic              message_en,
  output logic [2:0]        lane_valid,
  output logic [MSG_W-1:0]  message_1,
  output logic [MSG_W-1:0]  message_2,
  output logic [MSG_W-1:0]  message_3,
  output logic [CTRL_W-1:0] message_mux_control_m1,
  output logic [CTRL_W-1:0] message_mux_control_m2,
  output logic [CTRL_W-1:0] message_mux_control_m3,
  output logic [15:0]       drop_count
);

  logic [LANES-1:0] w_busy;
  logic [LANES-1:0] w_next_busy;
  logic [LANES-1:0] w_grantable;
  logic [LANES-1:0] w_pick_grant;
  logic [LANES-1:0] w_grant;
  logic             w_pick_any;
  logic [1:0]       w_next_ptr;
  logic [1:0]       r_ptr;
  logic             r_msg_en;
  logic             w_unknown;
  logic             w_dispatch;

`ifdef DISPATCH_TYPE_FILTER_EN
  assign w_unknown = !is_valid_code(32'(in_type));
`else
  assign w_unknown = 1'b0;
`endif

  // A lane being released this cycle can take the incoming message on the same edge.
  assign w_grantable = ~w_busy | (w_busy & lane_done);
  assign in_ready    = (|w_grantable) | w_unknown;
  assign w_dispatch  = in_valid && in_ready && !w_unknown;
  assign w_grant     = w_pick_grant & {LANES{w_dispatch}};

  stage5_rr_pick3 u_pick (
    .i_mask     (w_grantable),
    .i_ptr      (r_ptr),
    .o_grant    (w_pick_grant),
    .o_any      (w_pick_any),
    .o_next_ptr (w_next_ptr)
  );

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      lane_state_e       r_state;
      lane_state_e       w_state_next;
      logic [MSG_W-1:0]  r_msg;
      logic [CTRL_W-1:0] r_ctrl;

      assign w_busy[gi]      = (r_state == LANE_BUSY);
      assign w_next_busy[gi] = (w_state_next == LANE_BUSY);

      always_comb begin
        w_state_next = r_state;
        if (w_grant[gi]) begin
          w_state_next = LANE_BUSY;
        end else if (w_busy[gi] && lane_done[gi]) begin
          w_state_next = LANE_FREE;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= LANE_FREE;
          r_msg   <= '0;
          r_ctrl  <= IDLE_CODE;
        end else begin
          r_state <= w_state_next;
          if (w_grant[gi]) begin
            r_msg  <= in_message;
            r_ctrl <= in_type;
          end else if (w_busy[gi] && lane_done[gi]) begin
            r_ctrl <= IDLE_CODE;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= 2'd0;
      r_msg_en <= 1'b0;
    end else begin
      r_msg_en <= |w_next_busy;
      if (w_dispatch && w_pick_any) begin
        r_ptr <= w_next_ptr;
      end
    end
  end

`ifdef DISPATCH_TYPE_FILTER_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= 16'd0;
    end else if (in_valid && w_unknown && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = 16'd0;
`endif

  assign lane_valid             = w_busy;
  assign message_en             = r_msg_en;
  assign message_1              = g_lane[0].r_msg;
  assign message_2              = g_lane[1].r_msg;
  assign message_3              = g_lane[2].r_msg;
  assign message_mux_control_m1 = g_lane[0].r_ctrl;
  assign message_mux_control_m2 = g_lane[1].r_ctrl;
  assign message_mux_control_m3 = g_lane[2].r_ctrl;

endmodule

// File: tb/tb_stage5_lane_dispatch.sv
// Bench for stage5_lane_dispatch: directed scenarios plus random traffic against a
// lane-occupancy reference model. Filter scenarios build when DISPATCH_TYPE_FILTER_EN is set.
module tb_stage5_lane_dispatch;
  import stage5_lane_dispatch_pkg::*;

  localparam int MW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] in_message = '0;
  logic [CW-1:0] in_type = '0;
  logic [2:0]    lane_done = '0;
  logic          message_en;
  logic [2:0]    lane_valid;
  logic [MW-1:0] message_1, message_2, message_3;
  logic [CW-1:0] message_mux_control_m1, message_mux_control_m2, message_mux_control_m3;
  logic [15:0]   drop_count;

  stage5_lane_dispatch #(.MSG_W(MW), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_message(in_message), .in_type(in_type), .lane_done(lane_done),
    .message_en(message_en), .lane_valid(lane_valid),
    .message_1(message_1), .message_2(message_2), .message_3(message_3),
    .message_mux_control_m1(message_mux_control_m1),
    .message_mux_control_m2(message_mux_control_m2),
    .message_mux_control_m3(message_mux_control_m3),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what each lane holds, where the round-robin search starts, drops.
  bit            m_busy [3];
  logic [MW-1:0] m_msg  [3];
  logic [CW-1:0] m_ctrl [3];
  int            m_ptr;
  int            m_drop;
  logic          exp_ready;
  logic          obs_ready;
  int            last_lane;

  localparam logic [CW-1:0] T_D   = CW'(MUX_CODE_D);
  localparam logic [CW-1:0] T_BAD = 4'hF;

  function automatic bit model_known(input logic [CW-1:0] t);
`ifdef DISPATCH_TYPE_FILTER_EN
    return (t == 4'd1) || (t == 4'd2) || (t == 4'd3) || (t == 4'd4);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [2:0] model_lv();
    return {m_busy[2], m_busy[1], m_busy[0]};
  endfunction

  function automatic logic [MW-1:0] dut_msg(input int i);
    return (i == 0) ? message_1 : (i == 1) ? message_2 : message_3;
  endfunction

  function automatic logic [CW-1:0] dut_ctrl(input int i);
    return (i == 0) ? message_mux_control_m1 : (i == 1) ? message_mux_control_m2 : message_mux_control_m3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0;
      m_msg[i]  = '0;
      m_ctrl[i] = '0;
    end
    m_ptr = 0;
    m_drop = 0;
  endtask

  // Drives one cycle of stimulus, captures in_ready before the edge, then advances the model.
  task automatic step(input logic v, input logic [CW-1:0] t, input logic [MW-1:0] m, input logic [2:0] d);
    bit free_now [3];
    bit known;
    int chosen;
    @(negedge clk);
    in_valid = v; in_type = t; in_message = m; lane_done = d;
    #1;
    obs_ready = in_ready;
    known = model_known(t);
    for (int i = 0; i < 3; i++) free_now[i] = !m_busy[i] || d[i];
    exp_ready = free_now[0] || free_now[1] || free_now[2] || !known;
    @(posedge clk);
    chosen = -1;
    if (v && exp_ready) begin
      if (!known) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (chosen < 0 && free_now[(m_ptr + k) % 3]) chosen = (m_ptr + k) % 3;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (i == chosen) begin
        m_busy[i] = 1'b1; m_msg[i] = m; m_ctrl[i] = t;
      end else if (m_busy[i] && d[i]) begin
        m_busy[i] = 1'b0; m_ctrl[i] = '0;
      end
    end
    if (chosen >= 0) m_ptr = (chosen + 1) % 3;
    last_lane = chosen;
    #1;
    $display("txn t=%0t v=%0b type=%0h done=%03b ready=%0b lane=%0d lanes=%03b", $time, v, t, d, obs_ready, chosen + 1, lane_valid);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; lane_done = '0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (lane_valid !== 3'b000) begin n_err++; $display("FAIL reset_lane_valid got=%03b exp=000", lane_valid); end
    n_vec++; if (message_en !== 1'b0) begin n_err++; $display("FAIL reset_message_en got=%0b exp=0", message_en); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (dut_msg(i) !== '0) begin n_err++; $display("FAIL reset_message lane=%0d got=%h exp=0", i + 1, dut_msg(i)); end
      n_vec++; if (dut_ctrl(i) !== 4'd0) begin n_err++; $display("FAIL reset_mux_ctrl lane=%0d got=%h exp=0", i + 1, dut_ctrl(i)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] m;
    logic [2:0] lv_exp;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      m = {$urandom, $urandom};
      step(1'b1, T_D, m, 3'b000);
      lv_exp = 3'((1 << (k + 1)) - 1);
      n_vec++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready k=%0d got=%0b exp=1", k, obs_ready); end
      n_vec++; if (lane_valid !== lv_exp) begin n_err++; $display("FAIL b2b_lane_valid k=%0d got=%03b exp=%03b", k, lane_valid, lv_exp); end
      n_vec++; if (dut_msg(k) !== m) begin n_err++; $display("FAIL b2b_message lane=%0d got=%h exp=%h", k + 1, dut_msg(k), m); end
      n_vec++; if (dut_ctrl(k) !== T_D) begin n_err++; $display("FAIL b2b_mux_ctrl lane=%0d got=%h exp=%h", k + 1, dut_ctrl(k), T_D); end
    end
    n_vec++; if (message_en !== 1'b1) begin n_err++; $display("FAIL b2b_message_en got=%0b exp=1", message_en); end
    m = {$urandom, $urandom};
    step(1'b1, T_D, m, 3'b000);
    n_vec++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%0b exp=0", obs_ready); end
    n_vec++; if (message_2 === m) begin n_err++; $display("FAIL full_no_load got=%h must differ from held input", message_2); end
  endtask

  task automatic test_done_grant();
    logic [MW-1:0] m;
    m = in_message;
    step(1'b1, T_D, m, 3'b010);
    n_vec++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL done_grant_ready got=%0b exp=1", obs_ready); end
    n_vec++; if (lane_valid !== 3'b111) begin n_err++; $display("FAIL done_grant_lane_valid got=%03b exp=111", lane_valid); end
    n_vec++; if (message_2 !== m) begin n_err++; $display("FAIL done_grant_message_2 got=%h exp=%h", message_2, m); end
  endtask

  task automatic test_fairness();
    logic [MW-1:0] m;
    step(1'b1, T_D, {$urandom, $urandom}, 3'b001);
    step(1'b0, T_D, '0, 3'b101);
    n_vec++; if (lane_valid !== 3'b010) begin n_err++; $display("FAIL fair_setup got=%03b exp=010", lane_valid); end
    m = {$urandom, $urandom};
    step(1'b1, T_D, m, 3'b000);
    n_vec++; if (lane_valid !== 3'b110) begin n_err++; $display("FAIL fair_lane3 got=%03b exp=110", lane_valid); end
    n_vec++; if (message_3 !== m) begin n_err++; $display("FAIL fair_message_3 got=%h exp=%h", message_3, m); end
    m = {$urandom, $urandom};
    step(1'b1, T_D, m, 3'b000);
    n_vec++; if (lane_valid !== 3'b111) begin n_err++; $display("FAIL fair_ptr_lane1 got=%03b exp=111", lane_valid); end
    n_vec++; if (message_1 !== m) begin n_err++; $display("FAIL fair_message_1 got=%h exp=%h", message_1, m); end
  endtask

  task automatic test_release();
    step(1'b0, T_D, '0, 3'b001);
    n_vec++; if (lane_valid !== 3'b110) begin n_err++; $display("FAIL release_lane_valid got=%03b exp=110", lane_valid); end
    n_vec++; if (message_mux_control_m1 !== 4'd0) begin n_err++; $display("FAIL release_idle_code got=%h exp=0", message_mux_control_m1); end
    n_vec++; if (message_en !== 1'b1) begin n_err++; $display("FAIL release_message_en got=%0b exp=1", message_en); end
  endtask

  task automatic test_async_reset();
    step(1'b1, T_D, {$urandom, $urandom}, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++; if (lane_valid !== 3'b000) begin n_err++; $display("FAIL async_rst_lane_valid got=%03b exp=000", lane_valid); end
    n_vec++; if (message_en !== 1'b0) begin n_err++; $display("FAIL async_rst_message_en got=%0b exp=0", message_en); end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_type_filter();
    logic [MW-1:0] m;
    do_reset();
    step(1'b1, T_D, {$urandom, $urandom}, 3'b000);
`ifdef DISPATCH_TYPE_FILTER_EN
    for (int k = 0; k < 2; k++) begin
      step(1'b1, T_BAD, {$urandom, $urandom}, 3'b000);
      n_vec++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL filter_ready k=%0d got=%0b exp=1", k, obs_ready); end
      n_vec++; if (lane_valid !== 3'b001) begin n_err++; $display("FAIL filter_no_lane k=%0d got=%03b exp=001", k, lane_valid); end
    end
    n_vec++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL filter_drop_count got=%0d exp=2", drop_count); end
    m = {$urandom, $urandom};
    step(1'b1, T_D, m, 3'b000);
    n_vec++; if (lane_valid !== 3'b011 || message_2 !== m) begin n_err++; $display("FAIL filter_ptr_kept got=%03b/%h exp=011/%h", lane_valid, message_2, m); end
`else
    m = {$urandom, $urandom};
    step(1'b1, T_BAD, m, 3'b000);
    n_vec++; if (lane_valid !== 3'b011 || message_2 !== m) begin n_err++; $display("FAIL nofilter_dispatch got=%03b/%h exp=011/%h", lane_valid, message_2, m); end
    n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL nofilter_drop_count got=%0d exp=0", drop_count); end
`endif
  endtask

  task automatic test_random();
    logic          v;
    logic [CW-1:0] t;
    logic [MW-1:0] m;
    logic [2:0]    d;
    bit            hold;
    do_reset();
    hold = 1'b0;
    t = T_D; m = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        t = ($urandom_range(0, 7) == 0) ? T_BAD : CW'($urandom_range(1, 4));
        m = {$urandom, $urandom};
      end
      d = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      step(v, t, m, d);
      hold = v && !exp_ready;
      n_vec++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL rand_ready n=%0d got=%0b exp=%0b", n, obs_ready, exp_ready); end
      n_vec++; if (lane_valid !== model_lv()) begin n_err++; $display("FAIL rand_lane_valid n=%0d got=%03b exp=%03b", n, lane_valid, model_lv()); end
      n_vec++; if (message_en !== (|model_lv())) begin n_err++; $display("FAIL rand_message_en n=%0d got=%0b exp=%0b", n, message_en, |model_lv()); end
      n_vec++; if (drop_count !== 16'(m_drop)) begin n_err++; $display("FAIL rand_drop_count n=%0d got=%0d exp=%0d", n, drop_count, m_drop); end
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (dut_msg(i) !== m_msg[i]) begin n_err++; $display("FAIL rand_message n=%0d lane=%0d got=%h exp=%h", n, i + 1, dut_msg(i), m_msg[i]); end
        n_vec++; if (dut_ctrl(i) !== m_ctrl[i]) begin n_err++; $display("FAIL rand_mux_ctrl n=%0d lane=%0d got=%h exp=%h", n, i + 1, dut_ctrl(i), m_ctrl[i]); end
      end
    end
  endtask

  initial begin
    model_reset();
    last_lane = -1;
    test_reset();
    test_back_to_back();
    test_done_grant();
    test_fairness();
    test_release();
    test_async_reset();
    test_type_filter();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
